bus_arb_router: RTL
===================

# bus_arb_router

Parametrised successor to the single-bus generator/arbiter: a registered, FSM-driven arbiter and router sitting between `DRVRS` device FIFOs and one shared bus. It selects one pending device by round-robin or fixed priority, pops its head packet, decodes the destination ID and pushes the packet to one device or broadcasts it to all others. Unlike the previous generation, it honours per-destination back-pressure, drops packets on timeout, and optionally counts routing errors.

## Interface
- `DRVRS`, 4: number of attached devices (2..16)
- `PCKG_SZ`, 16: packet width in bits; ID field is bits `[PCKG_SZ-1 -: 8]`
- `BROADCAST`, 8'hFF: ID value meaning "all devices except source"
- `ARB_MODE`, 0: 0 = round-robin, 1 = fixed priority (lowest index wins)
- `TMO`, 16: max cycles spent in DELIVER before drop (1..255)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `pndng` in DRVRS: device FIFO non-empty
- `D_pop` in DRVRS*PCKG_SZ: show-ahead FIFO heads, device i at `[i*PCKG_SZ +: PCKG_SZ]`
- `rdy` in DRVRS: destination FIFO can accept a push
- `pop` out DRVRS: one-hot pop strobe to source FIFO
- `push` out DRVRS: push strobe(s) to destination FIFO(s)
- `D_push` out PCKG_SZ: bus data, shared by all destinations
- `busy` out 1: FSM not in IDLE
- `err_cnt` out 16: routing-error count (see Configuration)

## Operation
- All outputs registered; on reset: `pop`=0, `push`=0, `D_push`=0, `busy`=0, `err_cnt`=0, state IDLE, RR pointer = `DRVRS-1` (device 0 has highest priority first).
- IDLE: if any `pndng`, pick winner (RR: first set bit after last grant, wrapping; fixed: lowest index), register `src`, go POP. No `pndng` -> stay.
- POP: `pop[src]`=1 for exactly one cycle; `pkt` <= `D_pop[src]`; RR pointer <= `src`; go ROUTE.
- ROUTE: decode `dst = pkt[PCKG_SZ-1 -: 8]`.
  - `dst == BROADCAST`: target mask = all devices except `src`.
  - `dst < DRVRS` and `dst != src`: target mask = one-hot `dst`.
  - Otherwise (out of range or self-addressed): invalid; drop, count error, go IDLE.
  - Valid: clear wait counter, go DELIVER.
- DELIVER: when `(rdy & mask) == mask`, assert `push = mask` and `D_push = pkt` for one cycle, go IDLE. Otherwise increment wait counter; on reaching `TMO`, drop packet, count error, go IDLE. All-or-nothing: broadcast never pushes to a partial set.
- `pndng` changes during POP/ROUTE/DELIVER are ignored until the next IDLE.
- Reset mid-operation: in-flight packet is discarded; no `pop`/`push` pulse after reset assertion.

## Timing
- `pndng[i]` high before edge 0 in IDLE -> `pop[i]` high in cycle 1 -> ROUTE cycle 2 -> `push` high in cycle 3 if `rdy` is already set.
- Best-case throughput: one packet per 4 cycles; `busy` high for cycles 1..3.
- `D_push` holds the last pushed value until the next push.
- Timeout drop occurs `TMO` cycles after entering DELIVER; no push is issued in that cycle.
- `err_cnt` updates on the edge that leaves ROUTE or DELIVER. It saturates at 16'hFFFF.

## Configuration
- `BUS_ERR_CNT_EN`
  - Defined: `err_cnt` increments on each invalid-destination drop and each timeout drop.
  - Undefined: drops still occur identically; `err_cnt` is tied to 0 and the counter logic is removed.

## Test plan
- RR fairness: DRVRS=4, all `pndng`=4'b1111, all `rdy`=1, unicast packets -> pops occur in order 0,1,2,3,0, 4 cycles apart.
- Fixed priority (`ARB_MODE`=1): `pndng`=4'b1010 held -> device 1 is always popped; device 3 is never popped while device 1 stays pending.
- Broadcast: device 2 sends 16'hFF5A -> `push`=4'b1011, `D_push`=16'hFF5A for one cycle.
- Back-pressure/timeout: `TMO`=16, device 0 sends 16'h0377 with `rdy[3]`=0 -> no push, IDLE after 16 DELIVER cycles, `err_cnt`=1 (with `BUS_ERR_CNT_EN`).
- Invalid destination: device 1 sends 16'h0900 with DRVRS=4 -> `pop[1]` pulses, no push, `err_cnt` increments by 1; without the macro, `err_cnt` stays 0.
- Reset mid-DELIVER: assert `reset` while waiting on `rdy` -> all outputs 0 immediately; after release, arbitration restarts with device 0 highest priority.

Source files
------------

// File: rtl/bus_arb_router.sv
// ============================================================================
// Module   : bus_arb_router
// Purpose  : Round-robin / fixed-priority arbiter that pops one device FIFO,
//            decodes the destination ID and pushes unicast or broadcast with
//            per-destination back-pressure and timeout drop.
//            Optional macro BUS_ERR_CNT_EN enables the routing-error counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arb_router #(
  parameter int         DRVRS     = 4,
  parameter int         PCKG_SZ   = 16,
  parameter logic [7:0] BROADCAST = 8'hFF,
  parameter int         ARB_MODE  = 0,
  parameter int         TMO       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DRVRS-1:0]           pndng,
  input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
  input  logic [DRVRS-1:0]           rdy,
  output logic [DRVRS-1:0]           pop,
  output logic [DRVRS-1:0]           push,
  output logic [PCKG_SZ-1:0]         D_push,
  output logic                       busy,
  output logic [15:0]                err_cnt
);

  localparam int c_IW = (DRVRS > 1) ? $clog2(DRVRS) : 1;
  localparam logic [DRVRS-1:0] c_ONE = {{(DRVRS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_POP     = 2'd1,
    S_ROUTE   = 2'd2,
    S_DELIVER = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_IW-1:0]     r_src, r_rr_ptr, w_winner;
  logic [PCKG_SZ-1:0]  r_pkt, r_dpush, w_head;
  logic [DRVRS-1:0]    r_mask, r_pop, r_push;
  logic [DRVRS-1:0]    w_route_mask, w_src_oh, w_mask_cur;
  logic [DRVRS-1:0]    w_pop_nxt, w_push_nxt;
  logic [7:0]          r_wait, w_wait_nxt, w_dst;
  logic                r_busy;
  logic                w_route_valid, w_ready;
  logic                w_src_ld, w_pkt_ld, w_mask_ld, w_push_ld, w_err;

  // Round-robin: first requester strictly after the last grant, wrapping.
  function automatic logic [c_IW-1:0] f_rr_pick(input logic [DRVRS-1:0] req,
                                                input logic [c_IW-1:0]  last);
    logic [c_IW-1:0] pick;
    int              idx;
    pick = '0;
    for (int k = DRVRS; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= DRVRS) idx = idx - DRVRS;
      if (req[c_IW'(idx)]) pick = c_IW'(idx);
    end
    return pick;
  endfunction

  function automatic logic [c_IW-1:0] f_fixed_pick(input logic [DRVRS-1:0] req);
    logic [c_IW-1:0] pick;
    pick = '0;
    for (int k = DRVRS - 1; k >= 0; k--) begin
      if (req[c_IW'(k)]) pick = c_IW'(k);
    end
    return pick;
  endfunction

  always_comb begin
    w_winner = (ARB_MODE == 1) ? f_fixed_pick(pndng) : f_rr_pick(pndng, r_rr_ptr);
  end

  assign w_head = D_pop[int'(r_src)*PCKG_SZ +: PCKG_SZ];

  // Destination decode of the captured packet.
  always_comb begin
    w_dst         = r_pkt[PCKG_SZ-1 -: 8];
    w_src_oh      = c_ONE << r_src;
    w_route_mask  = '0;
    w_route_valid = 1'b0;
    if (w_dst == BROADCAST) begin
      w_route_mask  = ~w_src_oh;
      w_route_valid = 1'b1;
    end else if ((w_dst < 8'(DRVRS)) && (w_dst != 8'(r_src))) begin
      w_route_mask  = c_ONE << w_dst;
      w_route_valid = 1'b1;
    end
  end

  assign w_mask_cur = (r_state == S_ROUTE) ? w_route_mask : r_mask;
  assign w_ready    = ((rdy & w_mask_cur) == w_mask_cur);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop_nxt   = '0;
    w_push_nxt  = '0;
    w_wait_nxt  = r_wait;
    w_src_ld    = 1'b0;
    w_pkt_ld    = 1'b0;
    w_mask_ld   = 1'b0;
    w_push_ld   = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|pndng) begin
          w_state_nxt = S_POP;
          w_pop_nxt   = c_ONE << w_winner;
          w_src_ld    = 1'b1;
        end
      end
      S_POP: begin
        w_state_nxt = S_ROUTE;
        w_pkt_ld    = 1'b1;
      end
      S_ROUTE: begin
        if (!w_route_valid) begin
          w_state_nxt = S_IDLE;
          w_err       = 1'b1;
        end else begin
          w_state_nxt = S_DELIVER;
          w_mask_ld   = 1'b1;
          w_wait_nxt  = '0;
          if (w_ready) begin
            w_push_nxt = w_route_mask;
            w_push_ld  = 1'b1;
          end
        end
      end
      S_DELIVER: begin
        // A push already on the bus means this is the final DELIVER cycle.
        if (r_push != '0) begin
          w_state_nxt = S_IDLE;
        end else if (w_ready) begin
          w_push_nxt = r_mask;
          w_push_ld  = 1'b1;
        end else if (r_wait == 8'(TMO - 1)) begin
          w_state_nxt = S_IDLE;
          w_err       = 1'b1;
        end else begin
          w_wait_nxt = r_wait + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src    <= '0;
      r_rr_ptr <= c_IW'(DRVRS - 1);
      r_pkt    <= '0;
      r_mask   <= '0;
      r_wait   <= '0;
      r_pop    <= '0;
      r_push   <= '0;
      r_dpush  <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_pop  <= w_pop_nxt;
      r_push <= w_push_nxt;
      r_busy <= (w_state_nxt != S_IDLE);
      r_wait <= w_wait_nxt;
      if (w_src_ld) r_src <= w_winner;
      if (w_pkt_ld) begin
        r_pkt    <= w_head;
        r_rr_ptr <= r_src;
      end
      if (w_mask_ld) r_mask  <= w_route_mask;
      if (w_push_ld) r_dpush <= r_pkt;
    end
  end

`ifdef BUS_ERR_CNT_EN
  logic [15:0] r_err_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               r_err_cnt <= '0;
    else if (w_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
  end
  assign err_cnt = r_err_cnt;
`else
  logic w_unused_err;
  assign w_unused_err = w_err;
  assign err_cnt      = '0;
`endif

  assign pop    = r_pop;
  assign push   = r_push;
  assign D_push = r_dpush;
  assign busy   = r_busy;

endmodule

`default_nettype wire
